dmem_mmio: RTL and testbench

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio_pkg.sv | 31 +++
 rtl/mmio_tx_fifo.sv | 66 ++++++
 rtl/dmem_mmio.sv | 107 ++++++++++
 tb/tb_dmem_mmio.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for dmem_mmio: MMIO page base, register word offsets, TXSTAT bit layout.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_CYCLE  = 2'd1,
        REG_TXDATA = 2'd2,
        REG_TXSTAT = 2'd3
    } mmio_reg_e;

    localparam int TXSTAT_EMPTY_BIT = 0;
    localparam int TXSTAT_FULL_BIT  = 1;
    localparam int TXSTAT_OVF_BIT   = 2;
    localparam int TXSTAT_CNT_LSB   = 8;

    function automatic logic [31:0] txstat_pack(input logic [23:0] count,
                                                input logic        ovf,
                                                input logic        full,
                                                input logic        empty);
        logic [31:0] v;
        v                         = '0;
        v[31:TXSTAT_CNT_LSB]      = count;
        v[TXSTAT_OVF_BIT]         = ovf;
        v[TXSTAT_FULL_BIT]        = full;
        v[TXSTAT_EMPTY_BIT]       = empty;
        return v;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO behind the TXDATA register; pushes land at the head one cycle later, pops act on the edge.
// When full, a push is only taken alongside a pop; otherwise it is dropped and sets sticky overflow.
module mmio_tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  logic [7:0]                data_i,
    input  logic                      pop_i,
    input  logic                      clr_ovf_i,
    output logic [7:0]                data_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      overflow_o,
    output logic [$clog2(TX_DEPTH):0] count_o
);
    localparam int             PW      = $clog2(TX_DEPTH);
    localparam logic [PW:0]    DEPTH_C = TX_DEPTH[PW:0];

    logic [7:0]    mem_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          pop_ok, push_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign data_o     = mem_q[rd_ptr_q];
    assign overflow_o = ovf_q;
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        // A dropped push in the same cycle as a clear leaves overflow set.
        ovf_d = ovf_q;
        if (clr_ovf_i)           ovf_d = 1'b0;
        if (push_i && !push_ok)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !reset_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Core data memory: async-read word RAM (addr[31]=0) plus MMIO page (LED, CYCLE, TXDATA, TXSTAT).
// Stores commit on the rising edge; CYCLE counter is built only when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic [7:0]  leds,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_sel, mmio_hit;
    mmio_reg_e     reg_sel;
    logic [7:0]    leds_q, leds_d;
    logic [31:0]   cycle_rd;
    logic [31:0]   mmio_rdata;
    logic          fifo_push, fifo_clr_ovf;
    logic          fifo_empty, fifo_full, fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^alu_result_m[1:0];

    assign ram_sel  = !alu_result_m[31];
    assign ram_idx  = alu_result_m[AW+1:2];
    // Only the four words at the base decode; the rest of the page reads zero.
    assign mmio_hit = (alu_result_m[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = mmio_reg_e'(alu_result_m[3:2]);

    assign fifo_push    = dmem_write && mmio_hit && (reg_sel == REG_TXDATA);
    assign fifo_clr_ovf = dmem_write && mmio_hit && (reg_sel == REG_TXSTAT);

    always_ff @(posedge clk) begin
        if (dmem_write && ram_sel && !reset) ram_q[ram_idx] <= dmem_write_data;
    end

    always_comb begin
        leds_d = leds_q;
        if (dmem_write && mmio_hit && (reg_sel == REG_LED)) leds_d = dmem_write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) leds_q <= '0;
        else       leds_q <= leds_d;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    assign cycle_d = cycle_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_d;
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    mmio_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (fifo_push),
        .data_i     (dmem_write_data[7:0]),
        .pop_i      (tx_ready),
        .clr_ovf_i  (fifo_clr_ovf),
        .data_o     (tx_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .overflow_o (fifo_ovf),
        .count_o    (fifo_count)
    );

    always_comb begin
        mmio_rdata = '0;
        if (mmio_hit) begin
            case (reg_sel)
                REG_LED:    mmio_rdata = {24'b0, leds_q};
                REG_CYCLE:  mmio_rdata = cycle_rd;
                REG_TXDATA: mmio_rdata = '0;
                REG_TXSTAT: mmio_rdata = txstat_pack(24'(fifo_count), fifo_ovf, fifo_full, fifo_empty);
            endcase
        end
        dmem_read_data = ram_sel ? ram_q[ram_idx] : mmio_rdata;
    end

    assign leds     = leds_q;
    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus random traffic against a queue/array reference model.
module tb_dmem_mmio;
    localparam int RAM_WORDS = 64;
    localparam int TX_DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset, dmem_write, tx_ready, tx_valid;
    logic [31:0] alu_result_m, dmem_write_data, dmem_read_data;
    logic [7:0]  leds, tx_data;

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_WORDS(RAM_WORDS), .TX_DEPTH(TX_DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .alu_result_m    (alu_result_m),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .leds            (leds),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_ram   [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [7:0]  m_leds;
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    bit          m_ovf;
    bit          m_valid = 1'b0;

    logic [31:0] rd;
    logic [7:0]  drain_exp [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] d);
        int idx;
        d = 32'h0;
        if (!a[31]) begin
            idx = int'((a >> 2) % RAM_WORDS);
            d   = m_ram[idx];
            return m_known[idx];
        end
        if (a[30:4] != 27'h0) return 1'b1;
        case (a[3:2])
            2'd0: d = 32'(m_leds);
`ifdef DMEM_CYCLE_COUNTER_EN
            2'd1: d = m_cycle;
`else
            2'd1: d = 32'h0;
`endif
            2'd2: d = 32'h0;
            default: d = 32'(m_q.size()) * 256
                       + (m_ovf ? 32'd4 : 32'd0)
                       + ((m_q.size() == TX_DEPTH) ? 32'd2 : 32'd0)
                       + ((m_q.size() == 0) ? 32'd1 : 32'd0);
        endcase
        return 1'b1;
    endfunction

    // One clock cycle: apply inputs, check combinational/registered outputs, advance model, cross the edge.
    task automatic step(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit rdy, output logic [31:0] rdata);
        logic [31:0] exp;
        bit known, pop, full, hit, push, clr;
        int idx;
        reset           = rst;
        dmem_write      = we;
        alu_result_m    = a;
        dmem_write_data = wd;
        tx_ready        = rdy;
        #1;
        rdata = dmem_read_data;
        if (m_valid) begin
            known = model_read(a, exp);
            if (known) check("read_data", rdata, exp);
            check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
            check("leds", 32'(leds), 32'(m_leds));
        end
        if (rst) begin
            m_leds  = 8'h0;
            m_cycle = 32'h0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_cycle = m_cycle + 32'd1;
            full = (m_q.size() == TX_DEPTH);
            pop  = rdy && (m_q.size() != 0);
            hit  = a[31] && (a[30:4] == 27'h0);
            push = we && hit && (a[3:2] == 2'd2);
            clr  = we && hit && (a[3:2] == 2'd3);
            if (we && !a[31]) begin
                idx          = int'((a >> 2) % RAM_WORDS);
                m_ram[idx]   = wd;
                m_known[idx] = 1'b1;
            end
            if (we && hit && (a[3:2] == 2'd0)) m_leds = wd[7:0];
            if (pop) void'(m_q.pop_front());
            if (clr) m_ovf = 1'b0;
            if (push) begin
                if (!full || pop) m_q.push_back(wd[7:0]);
                else              m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        step(1, 0, 32'h0, 32'h0, 0, rd);
        step(1, 0, 32'h0, 32'h0, 0, rd);

        // Reset state, then 10 idle cycles before reading CYCLE
        step(0, 0, 32'h8000_000C, 32'h0, 0, rd);
        check("rst_txstat", rd, 32'h0000_0001);
        check("rst_leds", 32'(leds), 32'h0);
        for (int i = 0; i < 9; i++) step(0, 0, 32'h8000_0008, 32'h0, 1, rd);
        step(0, 0, 32'h8000_0004, 32'h0, 0, rd);
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cycle_after_10", rd, 32'd10);
`else
        check("cycle_after_10", rd, 32'd0);
`endif

        // RAM store/load and aliasing
        step(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd);
        step(0, 0, 32'h0000_0010, 32'h0, 0, rd);
        check("ram_load", rd, 32'hDEAD_BEEF);
        step(0, 0, 32'h0000_0010 + 4 * RAM_WORDS, 32'h0, 0, rd);
        check("ram_alias", rd, 32'hDEAD_BEEF);

        // LED register and unmapped MMIO
        step(0, 1, 32'h8000_0000, 32'h0000_01A5, 0, rd);
        check("leds_out", 32'(leds), 32'h0000_00A5);
        step(0, 0, 32'h8000_0000, 32'h0, 0, rd);
        check("led_read", rd, 32'h0000_00A5);
        step(0, 1, 32'h8000_0010, 32'hFFFF_FFFF, 0, rd);
        check("unmapped_read", rd, 32'h0);

        // Fill past full with no consumer
        for (int i = 1; i <= 9; i++) step(0, 1, 32'h8000_0008, 32'(i), 0, rd);
        step(0, 0, 32'h8000_000C, 32'h0, 0, rd);
        check("txstat_overflow", rd, 32'h0000_0806);
        check("head_0x01", 32'(tx_data), 32'h01);

        // Full with simultaneous push and pop
        step(0, 1, 32'h8000_0008, 32'h55, 1, rd);
        step(0, 0, 32'h8000_000C, 32'h0, 0, rd);
        check("full_push_pop", rd, 32'h0000_0806);

        // Clear overflow, then drain
        step(0, 1, 32'h8000_000C, 32'h0, 0, rd);
        step(0, 0, 32'h8000_000C, 32'h0, 0, rd);
        check("ovf_cleared", rd, 32'h0000_0802);
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'(i + 2);
        drain_exp[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 32'(tx_data), 32'(drain_exp[i]));
            step(0, 0, 32'h8000_0008, 32'h0, 1, rd);
        end
        check("drained_empty", 32'(tx_valid), 32'h0);

        // Empty FIFO: push and pop together only enqueues
        step(0, 1, 32'h8000_0008, 32'hA1, 1, rd);
        check("empty_push_pop", 32'(tx_valid), 32'h1);
        step(0, 1, 32'h8000_0008, 32'hA2, 0, rd);
        step(0, 1, 32'h8000_0008, 32'hA3, 1, rd);
        // Reset mid-drain overrides a simultaneous push and pop
        step(1, 1, 32'h8000_0008, 32'h77, 1, rd);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        step(0, 0, 32'h8000_000C, 32'h0, 0, rd);
        check("reset_txstat", rd, 32'h0000_0001);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = {1'b0, 31'($urandom)};
                4, 5, 6, 7: a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                8:          a = 32'h8000_0000 | (32'($urandom_range(1, 15)) << 4);
                default:    a = 32'h8000_0000 | 32'($urandom);
            endcase
            step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), a, 32'($urandom),
                 $urandom_range(0, 3) == 0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
